// File: rtl/bg_pkg.sv
// Shared types and palettes for the road/sky background generator.
package bg_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    REG_BLACK,
    REG_SKY,
    REG_ROAD,
    REG_LINE
  } region_t;

  localparam rgb_t DAY_LINE   = 24'hF0F0F0;
  localparam rgb_t DAY_ROAD   = 24'h525252;
  localparam rgb_t DAY_SKY    = 24'h87CEEB;
  localparam rgb_t NIGHT_LINE = 24'hF0D000;
  localparam rgb_t NIGHT_ROAD = 24'h202020;
  localparam rgb_t NIGHT_SKY  = 24'h101030;
  localparam rgb_t BLACK      = 24'h000000;

  function automatic rgb_t region_color(region_t region, logic night);
    rgb_t c;
    case (region)
      REG_LINE: c = night ? NIGHT_LINE : DAY_LINE;
      REG_ROAD: c = night ? NIGHT_ROAD : DAY_ROAD;
      REG_SKY:  c = night ? NIGHT_SKY  : DAY_SKY;
      default:  c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/scroll_offset_ctr.sv
// Per-frame scroll offset accumulator and frame-latched night flag.
module scroll_offset_ctr #(
  parameter int W = 7
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         i_new_frame,
  input  logic         i_pause,
  input  logic [W-1:0] i_speed,
  input  logic         i_night,
  output logic [W-1:0] o_offset,
  output logic         o_night
);

  logic [W-1:0] r_offset;
  logic         r_night;

  // Offset wraps naturally by truncation to W bits.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_offset <= '0;
      r_night  <= 1'b0;
    end else if (i_new_frame) begin
      r_night <= i_night;
      if (!i_pause) begin
        r_offset <= r_offset + i_speed;
      end
    end
  end

  assign o_offset = r_offset;
  assign o_night  = r_night;

endmodule

// File: rtl/road_scroll_bg.sv
// Two-stage road/sky background generator with scrolling dashed lane dividers.
module road_scroll_bg
  import bg_pkg::*;
#(
  parameter int ROAD_BOTTOM      = 710,
  parameter int ROAD_WIDTH       = 300,
  parameter int LANE_COUNT       = 2,
  parameter int DASH_PERIOD_LOG2 = 7,
  parameter int DASH_LEN         = 64,
  parameter int LINE_HALF        = 3
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic [10:0]                 hcount_in,
  input  logic [9:0]                  vcount_in,
  input  logic                        data_valid_in,
  input  logic                        new_frame_in,
  input  logic [DASH_PERIOD_LOG2-1:0] speed_in,
  input  logic                        pause_in,
  input  logic                        night_in,
  output logic [7:0]                  red_out,
  output logic [7:0]                  green_out,
  output logic [7:0]                  blue_out,
  output logic                        valid_out,
  output logic [DASH_PERIOD_LOG2-1:0] offset_out
);

  localparam int RT = ROAD_BOTTOM - ROAD_WIDTH;
  localparam logic [11:0] PHASE_MASK  = 12'((1 << DASH_PERIOD_LOG2) - 1);
  localparam logic [11:0] DASH_LEN_12 = 12'(DASH_LEN);

  logic [DASH_PERIOD_LOG2-1:0] w_offset;
  logic                        w_night;

  scroll_offset_ctr #(.W(DASH_PERIOD_LOG2)) u_scroll (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .i_new_frame (new_frame_in),
    .i_pause     (pause_in),
    .i_speed     (speed_in),
    .i_night     (night_in),
    .o_offset    (w_offset),
    .o_night     (w_night)
  );

  logic [31:0] w_v;
  logic [11:0] w_sum;
  logic        w_lit;
  logic        w_bottom;
  logic        w_top;
  logic        w_road;
  logic        w_sky;
  logic        w_div;

  assign w_v      = {22'd0, vcount_in};
  assign w_sum    = {1'b0, hcount_in} + {{(12 - DASH_PERIOD_LOG2){1'b0}}, w_offset};
  assign w_lit    = (w_sum & PHASE_MASK) < DASH_LEN_12;
  assign w_bottom = w_v >= 32'(ROAD_BOTTOM);
  assign w_top    = (w_v + 32'd10 >= 32'(RT)) && (w_v <= 32'(RT));
  assign w_road   = (w_v > 32'(RT)) && (w_v < 32'(ROAD_BOTTOM));
  assign w_sky    = w_v < 32'(RT);

  // Divider centres fold to constants; the +LINE_HALF on the left keeps the compare unsigned-safe.
  always_comb begin
    w_div = 1'b0;
    for (int k = 1; k < LANE_COUNT; k++) begin
      if ((w_v + 32'(LINE_HALF) >= 32'(ROAD_BOTTOM - (k * ROAD_WIDTH) / LANE_COUNT)) &&
          (w_v <= 32'(ROAD_BOTTOM - (k * ROAD_WIDTH) / LANE_COUNT + LINE_HALF))) begin
        w_div = 1'b1;
      end
    end
  end

  logic r_bottom;
  logic r_top;
  logic r_div_lit;
  logic r_road;
  logic r_sky;
  logic r_night;
  logic r_valid_s1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_bottom   <= 1'b0;
      r_top      <= 1'b0;
      r_div_lit  <= 1'b0;
      r_road     <= 1'b0;
      r_sky      <= 1'b0;
      r_night    <= 1'b0;
      r_valid_s1 <= 1'b0;
    end else begin
      r_bottom   <= w_bottom;
      r_top      <= w_top;
      r_div_lit  <= w_div & w_lit;
      r_road     <= w_road;
      r_sky      <= w_sky;
      r_night    <= w_night;
      r_valid_s1 <= data_valid_in;
    end
  end

  region_t w_region;

  always_comb begin
    w_region = REG_BLACK;
    if (r_bottom || r_top || r_div_lit) begin
      w_region = REG_LINE;
    end else if (r_road) begin
      w_region = REG_ROAD;
    end else if (r_sky) begin
      w_region = REG_SKY;
    end
  end

  rgb_t r_rgb;
  logic r_valid_s2;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_rgb      <= BLACK;
      r_valid_s2 <= 1'b0;
    end else begin
      r_rgb      <= region_color(w_region, r_night);
      r_valid_s2 <= r_valid_s1;
    end
  end

  assign red_out    = r_rgb.r;
  assign green_out  = r_rgb.g;
  assign blue_out   = r_rgb.b;
  assign valid_out  = r_valid_s2;
  assign offset_out = w_offset;

endmodule
